// File: rtl/mem_arb_defs.sv
// Shared encodings for the data-memory port arbiter: FSM states, owner IDs,
// and the inactive level of the active-low memory strobes.
package mem_arb_defs;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic OWNER_IF    = 1'b0;
  localparam logic OWNER_DM    = 1'b1;
  localparam logic STROBE_IDLE = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requesters, plus the
// next value of the fetch-starvation counter.
module mem_arb_pick #(
  parameter int MAX_STARVE = 4,
  parameter int CNT_W      = 3
) (
  input  logic             if_req,
  input  logic             dm_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_dm,
  output logic             grant_if,
  output logic [CNT_W-1:0] starve_cnt_nxt
);
  logic w_force_if;

  // Data wins ties until fetch has been passed over MAX_STARVE times in a row.
  assign w_force_if = if_req && (starve_cnt == CNT_W'(MAX_STARVE));
  assign grant_if   = if_req && (!dm_req || w_force_if);
  assign grant_dm   = dm_req && !grant_if;

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!if_req || grant_if)
      starve_cnt_nxt = '0;
    else if (grant_dm && (starve_cnt != CNT_W'(MAX_STARVE)))
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between instruction fetch and load/store,
// running every access as a fixed IDLE -> ACCESS -> RESP sequence.
module mem_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_write_n,
  output logic              mem_read_n,
  input  logic [DATA_W-1:0] mem_out
);
  localparam int CNT_W = $clog2(MAX_STARVE + 1);

  state_t            r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_we, w_we_nxt;
  logic              r_oor, w_oor_nxt;
  logic [CNT_W-1:0]  r_starve, w_starve_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_in, w_mem_in_nxt;
  logic              r_write_n, w_write_n_nxt;
  logic              r_read_n, w_read_n_nxt;
  logic              r_if_ack, w_if_ack_nxt;
  logic              r_dm_ack, w_dm_ack_nxt;
  logic              r_err, w_err_nxt;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
  logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata_nxt;
  logic              r_busy, w_busy_nxt;

  logic              w_grant_dm, w_grant_if;
  logic [CNT_W-1:0]  w_pick_starve;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_oor;

  mem_arb_pick #(.MAX_STARVE(MAX_STARVE), .CNT_W(CNT_W)) u_pick (
    .if_req         (if_req),
    .dm_req         (dm_req),
    .starve_cnt     (r_starve),
    .grant_dm       (w_grant_dm),
    .grant_if       (w_grant_if),
    .starve_cnt_nxt (w_pick_starve)
  );

  assign w_sel_addr = w_grant_dm ? dm_addr : if_addr;
  assign w_sel_oor  = {1'b0, w_sel_addr} >= (ADDR_W + 1)'(DEPTH);

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_we_nxt       = r_we;
    w_oor_nxt      = r_oor;
    w_starve_nxt   = r_starve;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_in_nxt   = r_mem_in;
    w_write_n_nxt  = STROBE_IDLE;
    w_read_n_nxt   = STROBE_IDLE;
    w_if_ack_nxt   = 1'b0;
    w_dm_ack_nxt   = 1'b0;
    w_err_nxt      = 1'b0;
    w_if_rdata_nxt = r_if_rdata;
    w_dm_rdata_nxt = r_dm_rdata;
    w_busy_nxt     = r_busy;
    case (r_state)
      ST_IDLE: begin
        w_starve_nxt = w_pick_starve;
        if (w_grant_if || w_grant_dm) begin
          w_owner_nxt    = w_grant_if ? OWNER_IF : OWNER_DM;
          w_we_nxt       = w_grant_dm && dm_we;
          w_oor_nxt      = w_sel_oor;
          w_mem_addr_nxt = w_sel_addr;
          if (w_grant_dm) w_mem_in_nxt = dm_wdata;
          // Out-of-range accesses still take three cycles but never touch the memory.
          if (!w_sel_oor) begin
            w_write_n_nxt = !(w_grant_dm && dm_we);
            w_read_n_nxt  = w_grant_dm && dm_we;
          end
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Memory acted on the mid-cycle negedge, so mem_out is valid here.
        w_err_nxt = r_oor;
        if (r_owner == OWNER_IF) begin
          w_if_ack_nxt   = 1'b1;
          w_if_rdata_nxt = r_oor ? '0 : mem_out;
        end else begin
          w_dm_ack_nxt   = 1'b1;
          w_dm_rdata_nxt = (r_we || r_oor) ? '0 : mem_out;
        end
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWNER_IF;
      r_we       <= 1'b0;
      r_oor      <= 1'b0;
      r_starve   <= '0;
      r_mem_addr <= '0;
      r_mem_in   <= '0;
      r_write_n  <= STROBE_IDLE;
      r_read_n   <= STROBE_IDLE;
      r_if_ack   <= 1'b0;
      r_dm_ack   <= 1'b0;
      r_err      <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_we       <= w_we_nxt;
      r_oor      <= w_oor_nxt;
      r_starve   <= w_starve_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_in   <= w_mem_in_nxt;
      r_write_n  <= w_write_n_nxt;
      r_read_n   <= w_read_n_nxt;
      r_if_ack   <= w_if_ack_nxt;
      r_dm_ack   <= w_dm_ack_nxt;
      r_err      <= w_err_nxt;
      r_if_rdata <= w_if_rdata_nxt;
      r_dm_rdata <= w_dm_rdata_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign if_ack      = r_if_ack;
  assign if_rdata    = r_if_rdata;
  assign dm_ack      = r_dm_ack;
  assign dm_rdata    = r_dm_rdata;
  assign err         = r_err;
  assign busy        = r_busy;
  assign mem_addr    = r_mem_addr;
  assign mem_in      = r_mem_in;
  assign mem_write_n = r_write_n;
  assign mem_read_n  = r_read_n;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses from a
// reference memory, a negedge monitor pops and compares on every ack.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [5:0]  if_addr = '0;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [5:0]  dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic        dm_ack;
  logic [15:0] dm_rdata;
  logic        err, busy;
  logic [5:0]  mem_addr;
  logic [15:0] mem_in;
  logic        mem_write_n, mem_read_n;
  logic [15:0] mem_out;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .err(err), .busy(busy),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_write_n(mem_write_n),
    .mem_read_n(mem_read_n), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural memory device: strobes sampled on negedge, registered read data.
  logic [15:0] pre [32];
  logic [15:0] env_mem [32];
  logic        preload = 1'b1;
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= pre[i];
      mem_out <= '0;
    end else begin
      if (!mem_write_n && mem_addr < 6'd32) env_mem[mem_addr[4:0]] <= mem_in;
      if (!mem_read_n && mem_addr < 6'd32) mem_out <= env_mem[mem_addr[4:0]];
    end
  end

  // Reference model state and scoreboard.
  logic [15:0] ref_mem [32];
  logic [16:0] dm_q[$];
  logic [16:0] if_q[$];
  bit          grant_log[$];
  int          rd_lows = 0, wr_lows = 0, dm_acks = 0;
  bit          prev_low = 1'b0;
  logic [16:0] e_dm, e_if;

  always @(negedge clk) begin
    if (!reset) begin
      if (dm_ack) begin
        dm_acks++;
        grant_log.push_back(1'b1);
        if (dm_q.size() == 0) chk("dm_unexpected_ack", 32'd1, 32'd0);
        else begin
          e_dm = dm_q.pop_front();
          chk("dm_rdata", 32'(dm_rdata), 32'(e_dm[15:0]));
          chk("dm_err", 32'(err), 32'(e_dm[16]));
        end
      end
      if (if_ack) begin
        grant_log.push_back(1'b0);
        if (if_q.size() == 0) chk("if_unexpected_ack", 32'd1, 32'd0);
        else begin
          e_if = if_q.pop_front();
          chk("if_rdata", 32'(if_rdata), 32'(e_if[15:0]));
          chk("if_err", 32'(err), 32'(e_if[16]));
        end
      end
      if (dm_ack && if_ack) chk("both_acks", 32'd1, 32'd0);
      if ((dm_ack || if_ack) && !busy) chk("ack_outside_resp", 32'd1, 32'd0);
      if (err && !dm_ack && !if_ack) chk("err_without_ack", 32'd1, 32'd0);
      if (!mem_read_n || !mem_write_n) begin
        chk("strobe_both_low", 32'(!mem_read_n && !mem_write_n), 32'd0);
        chk("strobe_in_range", 32'(mem_addr < 6'd32), 32'd1);
        chk("strobe_one_cycle", 32'(prev_low), 32'd0);
        chk("strobe_busy", 32'(busy), 32'd1);
      end
      if (!mem_read_n) rd_lows++;
      if (!mem_write_n) wr_lows++;
      prev_low = !mem_read_n || !mem_write_n;
    end
  end

  // Both driver tasks assume entry just after a posedge and return just after one.
  task automatic dm_op(input logic we, input logic [5:0] addr, input logic [15:0] wd,
                       input int exp_lat);
    logic oor;
    logic [15:0] exp;
    int n;
    bit got;
    oor = (addr >= 6'd32);
    exp = (we || oor) ? 16'h0 : ref_mem[addr[4:0]];
    if (we && !oor) ref_mem[addr[4:0]] = wd;
    dm_q.push_back({oor, exp});
    dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
    n = 0; got = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (dm_ack) got = 1;
    end
    if (!got) chk("dm_ack_timeout", 32'd0, 32'd1);
    else if (exp_lat != 0) chk("dm_latency", 32'(n), 32'(exp_lat));
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  task automatic if_op(input logic [5:0] addr, input int exp_lat);
    logic oor;
    int n;
    bit got;
    oor = (addr >= 6'd32);
    if_q.push_back({oor, oor ? 16'h0 : ref_mem[addr[4:0]]});
    if_req = 1'b1; if_addr = addr;
    n = 0; got = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (if_ack) got = 1;
    end
    if (!got) chk("if_ack_timeout", 32'd0, 32'd1);
    else if (exp_lat != 0) chk("if_latency", 32'(n), 32'(exp_lat));
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int r0, w0, a0;
    logic [5:0] a;
    for (int i = 0; i < 32; i++) pre[i] = 16'($urandom);
    pre[0] = 16'h02F0;
    for (int i = 0; i < 32; i++) ref_mem[i] = pre[i];

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_write_n", 32'(mem_write_n), 32'd1);
    chk("rst_read_n", 32'(mem_read_n), 32'd1);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_in", 32'(mem_in), 32'd0);
    chk("rst_acks_err_busy", 32'({if_ack, dm_ack, err, busy}), 32'd0);
    chk("rst_rdata", 32'({if_rdata, dm_rdata}), 32'd0);
    preload = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    idle(1);

    // Reset in the middle of a store's ACCESS cycle
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 6'd5; dm_wdata = ~pre[5];
    @(posedge clk); #1;
    chk("abort_write_low", 32'(mem_write_n), 32'd0);
    reset = 1'b1;
    #1;
    chk("abort_write_n", 32'(mem_write_n), 32'd1);
    chk("abort_read_n", 32'(mem_read_n), 32'd1);
    chk("abort_acks_busy", 32'({if_ack, dm_ack, busy}), 32'd0);
    dm_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_mem5", 32'(env_mem[5]), 32'(pre[5]));
    @(posedge clk); #1; reset = 1'b0;
    idle(1);

    // Store then load
    w0 = wr_lows;
    dm_op(1'b1, 6'd3, 16'hBEEF, 3);
    chk("store_write_pulses", 32'(wr_lows - w0), 32'd1);
    dm_op(1'b0, 6'd3, 16'h0, 3);

    // Fetch only
    r0 = rd_lows; w0 = wr_lows;
    if_op(6'd0, 3);
    chk("fetch_read_pulses", 32'(rd_lows - r0), 32'd1);
    chk("fetch_write_pulses", 32'(wr_lows - w0), 32'd0);

    // Out of range
    r0 = rd_lows; w0 = wr_lows;
    dm_op(1'b0, 6'd40, 16'h0, 3);
    dm_op(1'b1, 6'd63, 16'h5555, 3);
    chk("oor_read_pulses", 32'(rd_lows - r0), 32'd0);
    chk("oor_write_pulses", 32'(wr_lows - w0), 32'd0);

    // Back-to-back requests on the data port
    a0 = dm_acks;
    for (int k = 0; k < 3; k++) dm_op(1'b0, 6'($urandom_range(0, 31)), 16'h0, 3);
    idle(4);
    chk("b2b_ack_count", 32'(dm_acks - a0), 32'd3);

    // Contention: both held continuously, expect D,D,D,D,I repeating
    grant_log.delete();
    fork
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 1) != 0) dm_op(1'b1, 6'($urandom_range(16, 31)), 16'($urandom), 0);
        else dm_op(1'b0, 6'($urandom_range(0, 31)), 16'h0, 0);
      end
      for (int k = 0; k < 2; k++) if_op(6'($urandom_range(0, 15)), 0);
    join
    idle(2);
    chk("contention_grants", 32'(grant_log.size()), 32'd10);
    if (grant_log.size() == 10)
      for (int k = 0; k < 10; k++) chk("contention_order", 32'(grant_log[k]), 32'((k % 5) != 4));

    // Randomized mixed traffic
    fork
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 1) != 0) begin
          a = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(16, 31));
          dm_op(1'b1, a, 16'($urandom), 0);
        end else begin
          a = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
          dm_op(1'b0, a, 16'h0, 0);
        end
        idle($urandom_range(0, 3));
      end
      for (int k = 0; k < 30; k++) begin
        if_op(($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 15)), 0);
        idle($urandom_range(0, 3));
      end
    join
    idle(4);

    chk("dm_queue_empty", 32'(dm_q.size()), 32'd0);
    chk("if_queue_empty", 32'(if_q.size()), 32'd0);
    for (int i = 0; i < 32; i++) chk("final_mem", 32'(env_mem[i]), 32'(ref_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
